k12a_clock_gen: RTL and testbench
=================================

K12A_CLOCK_GEN -- requirements
Module: k12a_clock_gen

Interface
REQ-001 SHALL have parameter DIV_WIDTH, default 4: width of the divide-ratio input; legal range 1..16.
REQ-002 SHALL have port sys_clock, input, 1 bit: the single system clock; all state changes on its rising edge.
REQ-003 SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port div_ratio, input, DIV_WIDTH bits: each cpu_clock phase lasts div_ratio+1 sys_clock cycles.
REQ-005 SHALL have port halt_req, input, 1 bit: level request to stop cpu_clock low at the next LOW-phase end.
REQ-006 SHALL have port step_req, input, 1 bit: one-cycle pulse requesting a single cpu_clock cycle while halted.
REQ-007 SHALL have port cpu_clock, output, 1 bit: divided CPU clock, driven directly from a flop.
REQ-008 SHALL have port write_strobe, output, 1 bit: asynchronous-memory write enable, driven directly from a flop.
REQ-009 SHALL have port halted, output, 1 bit: high while in HALTED.
REQ-010 SHALL have port step_ack, output, 1 bit: one-cycle pulse when a step completes.

Function
REQ-011 SHALL implement states LOW, HIGH and HALTED, plus a step-pending flag; cpu_clock=1 only in HIGH.
REQ-012 SHALL keep a DIV_WIDTH-bit down-counter; an edge with counter==0 ends the phase and reloads the counter from div_ratio sampled at that edge; otherwise it decrements.
REQ-013 SHALL apply a div_ratio change only at the next phase boundary, never mid-phase.
REQ-014 SHALL, with div_ratio=0, toggle cpu_clock on every sys_clock edge (period 2 cycles).
REQ-015 SHALL end a HIGH phase by entering LOW.
REQ-016 SHALL end a LOW phase by entering HIGH when halt_req=0 and no step is pending.
REQ-017 SHALL end a LOW phase by entering HALTED, with cpu_clock held low, when halt_req=1 or a step is pending.
REQ-018 SHALL, in HALTED with halt_req=0, enter HIGH at the next edge and reload the counter.
REQ-019 SHALL, in HALTED with halt_req=1 and step_req=1, enter HIGH, set step-pending, and complete exactly one HIGH phase and one LOW phase before returning to HALTED.
REQ-020 SHALL pulse step_ack for one cycle on the edge that returns to HALTED from a step, then clear step-pending.
REQ-021 SHALL ignore step_req outside HALTED and while a step is pending.
REQ-022 SHALL assert write_strobe only during the final sys_clock cycle of each counted LOW phase (counter==0 in LOW).
REQ-023 SHALL never assert write_strobe in HALTED, and SHALL NOT assert it in the LOW phase immediately following reset.
REQ-024 SHALL keep write_strobe and cpu_clock mutually exclusive in every cycle.

Reset
REQ-025 SHALL, on reset_n low, immediately force state LOW, counter 0, step-pending 0, cpu_clock 0, write_strobe 0, halted 0, step_ack 0, regardless of the current phase.
REQ-026 SHALL raise cpu_clock at the first sys_clock rising edge after reset_n deasserts, if halt_req=0.

Configuration
REQ-027 SHALL, when macro K12A_CLOCK_STEP_EN is defined, implement single-step as REQ-019..REQ-021.
REQ-028 SHALL, when K12A_CLOCK_STEP_EN is undefined, omit the step-pending logic, ignore step_req, and tie step_ack to 0; all other behaviour is unchanged.

Verification
REQ-029 SHALL cover: div_ratio=0, halt_req=0 -> cpu_clock rises on edge 1 after reset, then period 2; write_strobe high in every LOW cycle from the second LOW phase on.
REQ-030 SHALL cover: div_ratio=3 -> cpu_clock 4 cycles high / 4 cycles low; write_strobe one cycle per 8, in the last LOW cycle.
REQ-031 SHALL cover: div_ratio changed 3->1 mid-HIGH -> current phase stays 4 cycles, following phases last 2 cycles.
REQ-032 SHALL cover: halt_req=1 during HIGH -> HIGH completes, LOW completes with strobe, then halted=1 and cpu_clock=0 held; halt_req=0 -> cpu_clock rises next edge.
REQ-033 SHALL cover: with STEP_EN, halted, div_ratio=1, step_req pulse -> 2 HIGH + 2 LOW cycles, one strobe, step_ack pulse, halted=1 again; a second step_req during the step is ignored; without STEP_EN -> no cpu_clock edge and step_ack stays 0.
REQ-034 SHALL cover: reset_n low mid-HIGH with div_ratio=7 -> cpu_clock=0 and write_strobe=0 immediately, without waiting for a sys_clock edge.

Source files
------------

// File: rtl/k12a_clock_gen.sv
// k12a_clock_gen: divided CPU clock with halt, write strobe and optional single-step.
// Single-step support is compiled in only when K12A_CLOCK_STEP_EN is defined.
module k12a_clock_gen #(
    parameter int DIV_WIDTH = 4
) (
    input  logic                 sys_clock,
    input  logic                 reset_n,
    input  logic [DIV_WIDTH-1:0] div_ratio,
    input  logic                 halt_req,
    input  logic                 step_req,
    output logic                 cpu_clock,
    output logic                 write_strobe,
    output logic                 halted,
    output logic                 step_ack
);
    typedef enum logic [1:0] {LOW, HIGH, HALTED} state_t;

    state_t               state_q, state_d;
    logic [DIV_WIDTH-1:0] cnt_q, cnt_d;
    logic                 cpu_clock_q, cpu_clock_d;
    logic                 write_strobe_q, write_strobe_d;
    logic                 halted_q, halted_d;
    logic                 phase_end, step_pend, step_start;

    assign phase_end = (cnt_q == '0);

`ifdef K12A_CLOCK_STEP_EN
    logic step_pend_q, step_pend_d, step_ack_q, step_ack_d;

    assign step_pend  = step_pend_q;
    assign step_start = (state_q == HALTED) && halt_req && step_req;

    always_comb begin
        step_ack_d  = (state_q == LOW) && phase_end && step_pend_q;
        step_pend_d = step_start ? 1'b1 : step_ack_d ? 1'b0 : step_pend_q;
    end

    always_ff @(posedge sys_clock or negedge reset_n) begin
        if (!reset_n) begin
            step_pend_q <= 1'b0;
            step_ack_q  <= 1'b0;
        end else begin
            step_pend_q <= step_pend_d;
            step_ack_q  <= step_ack_d;
        end
    end

    assign step_ack = step_ack_q;
`else
    logic unused_step_req;

    assign unused_step_req = step_req;
    assign step_pend       = 1'b0;
    assign step_start      = 1'b0;
    assign step_ack        = 1'b0;
`endif

    // Outputs are registered from the next state so they change exactly with the phase.
    always_comb begin
        state_d = (state_q == HALTED) ? ((!halt_req || step_start) ? HIGH : HALTED)
                : !phase_end          ? state_q
                : (state_q == HIGH)   ? LOW
                : (halt_req || step_pend) ? HALTED : HIGH;
        cnt_d          = (phase_end || state_q == HALTED) ? div_ratio : cnt_q - 1'b1;
        cpu_clock_d    = (state_d == HIGH);
        write_strobe_d = (state_d == LOW) && (cnt_d == '0);
        halted_d       = (state_d == HALTED);
    end

    always_ff @(posedge sys_clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= LOW;
            cnt_q          <= '0;
            cpu_clock_q    <= 1'b0;
            write_strobe_q <= 1'b0;
            halted_q       <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            cpu_clock_q    <= cpu_clock_d;
            write_strobe_q <= write_strobe_d;
            halted_q       <= halted_d;
        end
    end

    assign cpu_clock    = cpu_clock_q;
    assign write_strobe = write_strobe_q;
    assign halted       = halted_q;
endmodule

// File: tb/tb_k12a_clock_gen.sv
// tb_k12a_clock_gen: randomized self-checking bench against a phase-position reference model.
module tb_k12a_clock_gen;
    localparam int DIV_WIDTH = 4;
`ifdef K12A_CLOCK_STEP_EN
    localparam bit STEP_EN = 1'b1;
`else
    localparam bit STEP_EN = 1'b0;
`endif

    logic                 sys_clock = 1'b0;
    logic                 reset_n = 1'b1;
    logic [DIV_WIDTH-1:0] div_ratio = '0;
    logic                 halt_req = 1'b0;
    logic                 step_req = 1'b0;
    logic                 cpu_clock, write_strobe, halted, step_ack;

    int checks = 0;
    int errors = 0;

    // Model: mode 0=low 1=high 2=halted; pos counts cycles into a phase of length len.
    int m_mode, m_pos, m_len;
    bit m_step, m_ack, m_first;

    k12a_clock_gen #(.DIV_WIDTH(DIV_WIDTH)) dut (
        .sys_clock(sys_clock), .reset_n(reset_n), .div_ratio(div_ratio),
        .halt_req(halt_req), .step_req(step_req), .cpu_clock(cpu_clock),
        .write_strobe(write_strobe), .halted(halted), .step_ack(step_ack)
    );

    always #5 sys_clock = ~sys_clock;

    task automatic model_reset();
        m_mode = 0; m_pos = 0; m_len = 1; m_step = 0; m_ack = 0; m_first = 1;
    endtask

    task automatic model_edge();
        bit last = (m_pos == m_len - 1);
        m_ack = 0;
        if (m_mode == 2) begin
            if (!halt_req || (STEP_EN && step_req)) begin
                m_mode = 1; m_pos = 0; m_len = int'(div_ratio) + 1;
                if (halt_req) m_step = 1;
            end
        end else if (last) begin
            if (m_mode == 1) m_mode = 0;
            else if (halt_req || m_step) begin
                m_mode = 2; m_ack = m_step; m_step = 0;
            end else m_mode = 1;
            m_pos = 0; m_len = int'(div_ratio) + 1; m_first = 0;
        end else m_pos++;
    endtask

    function automatic logic [3:0] exp_out();
        return {m_mode == 1, m_mode == 0 && m_pos == m_len - 1 && !m_first, m_mode == 2, m_ack};
    endfunction

    task automatic tick();
        model_edge();
        @(posedge sys_clock);
        #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        #1;
        @(posedge sys_clock);
        #1;
        model_reset();
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        div_ratio = 0; halt_req = 0; step_req = 0;
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if ({cpu_clock, write_strobe, halted, step_ack} !== 4'b0000) begin
            errors++; $display("FAIL reset_outputs got=%b exp=0000", {cpu_clock, write_strobe, halted, step_ack});
        end
        @(posedge sys_clock);
        #1;
        model_reset();
        reset_n = 1'b1;
        tick();
        checks++;
        if (cpu_clock !== 1'b1) begin
            errors++; $display("FAIL first_edge_rise got=%b exp=1", cpu_clock);
        end
        for (int i = 0; i < 20; i++) begin
            tick();
            checks++;
            if ({cpu_clock, write_strobe, halted, step_ack} !== exp_out()) begin
                errors++; $display("FAIL div0_cycle%0d got=%b exp=%b", i, {cpu_clock, write_strobe, halted, step_ack}, exp_out());
            end
        end
    endtask

    task automatic test_div3();
        int hi = 0, st = 0;
        div_ratio = 3; halt_req = 0;
        do_reset();
        for (int i = 0; i < 32; i++) begin
            tick();
            hi += int'(cpu_clock); st += int'(write_strobe);
            checks++;
            if ({cpu_clock, write_strobe, halted, step_ack} !== exp_out()) begin
                errors++; $display("FAIL div3_cycle%0d got=%b exp=%b", i, {cpu_clock, write_strobe, halted, step_ack}, exp_out());
            end
        end
        checks++;
        if (hi != 16 || st != 4) begin
            errors++; $display("FAIL div3_counts got hi=%0d st=%0d exp hi=16 st=4", hi, st);
        end
    endtask

    task automatic test_ratio_change();
        logic [11:0] seq;
        div_ratio = 3; halt_req = 0;
        do_reset();
        tick();
        tick();
        div_ratio = 1;
        for (int i = 0; i < 12; i++) begin
            tick();
            seq[11-i] = cpu_clock;
            checks++;
            if ({cpu_clock, write_strobe, halted, step_ack} !== exp_out()) begin
                errors++; $display("FAIL ratio_cycle%0d got=%b exp=%b", i, {cpu_clock, write_strobe, halted, step_ack}, exp_out());
            end
        end
        checks++;
        if (seq !== 12'b110011001100) begin
            errors++; $display("FAIL ratio_sequence got=%b exp=110011001100", seq);
        end
    endtask

    task automatic test_halt();
        bit strobe_seen = 0;
        int n = 0;
        div_ratio = 2; halt_req = 0;
        do_reset();
        tick();
        halt_req = 1;
        while (!halted && n < 40) begin
            tick();
            n++;
            strobe_seen |= write_strobe;
            checks++;
            if ({cpu_clock, write_strobe, halted, step_ack} !== exp_out()) begin
                errors++; $display("FAIL halt_cycle%0d got=%b exp=%b", n, {cpu_clock, write_strobe, halted, step_ack}, exp_out());
            end
        end
        checks++;
        if (halted !== 1'b1 || strobe_seen !== 1'b1) begin
            errors++; $display("FAIL halt_reached got halted=%b strobe=%b exp 1 1", halted, strobe_seen);
        end
        for (int i = 0; i < 8; i++) begin
            tick();
            checks++;
            if ({cpu_clock, write_strobe, halted} !== 3'b001) begin
                errors++; $display("FAIL halt_hold%0d got=%b exp=001", i, {cpu_clock, write_strobe, halted});
            end
        end
        halt_req = 0;
        tick();
        checks++;
        if ({cpu_clock, halted} !== 2'b10) begin
            errors++; $display("FAIL halt_release got=%b exp=10", {cpu_clock, halted});
        end
    endtask

    task automatic test_step();
        int hi = 0, st = 0, ack = 0;
        div_ratio = 1; halt_req = 1; step_req = 0;
        do_reset();
        tick();
        tick();
        step_req = 1;
        for (int i = 0; i < 11; i++) begin
            tick();
            step_req = (i == 0);
            hi += int'(cpu_clock); st += int'(write_strobe); ack += int'(step_ack);
            checks++;
            if ({cpu_clock, write_strobe, halted, step_ack} !== exp_out()) begin
                errors++; $display("FAIL step_cycle%0d got=%b exp=%b", i, {cpu_clock, write_strobe, halted, step_ack}, exp_out());
            end
        end
        step_req = 0;
        checks++;
        if (hi != (STEP_EN ? 2 : 0) || st != (STEP_EN ? 1 : 0) || ack != (STEP_EN ? 1 : 0) || halted !== 1'b1) begin
            errors++; $display("FAIL step_counts got hi=%0d st=%0d ack=%0d halted=%b exp hi=%0d st=%0d ack=%0d halted=1",
                               hi, st, ack, halted, STEP_EN ? 2 : 0, STEP_EN ? 1 : 0, STEP_EN ? 1 : 0);
        end
        halt_req = 0;
    endtask

    task automatic test_async_reset();
        div_ratio = 7; halt_req = 0;
        do_reset();
        tick();
        tick();
        tick();
        checks++;
        if (cpu_clock !== 1'b1) begin
            errors++; $display("FAIL async_pre got=%b exp=1", cpu_clock);
        end
        #3 reset_n = 1'b0;
        #1;
        checks++;
        if ({cpu_clock, write_strobe} !== 2'b00) begin
            errors++; $display("FAIL async_reset got=%b exp=00", {cpu_clock, write_strobe});
        end
        do_reset();
    endtask

    task automatic test_random();
        div_ratio = 0; halt_req = 0; step_req = 0;
        do_reset();
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 15) == 0) div_ratio = DIV_WIDTH'($urandom_range(0, 15));
            if ($urandom_range(0, 19) == 0) halt_req = ~halt_req;
            step_req = ($urandom_range(0, 5) == 0);
            tick();
            checks++;
            if ({cpu_clock, write_strobe, halted, step_ack} !== exp_out()) begin
                errors++; $display("FAIL random_cycle%0d got=%b exp=%b", i, {cpu_clock, write_strobe, halted, step_ack}, exp_out());
            end
            checks++;
            if ((cpu_clock & write_strobe) !== 1'b0) begin
                errors++; $display("FAIL exclusive_cycle%0d got=%b exp=0", i, cpu_clock & write_strobe);
            end
        end
        step_req = 0; halt_req = 0;
    endtask

    initial begin
        test_reset();
        test_div3();
        test_ratio_change();
        test_halt();
        test_step();
        test_async_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end
endmodule
